dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter and burst sequencer in front of the single-port word data memory. Port 0 is the pipeline MEM stage: single-beat accesses, normally highest priority. Port 1 is a bulk requester (loader/DMA): bursts of 1–16 consecutive words with auto-incremented addresses. The block issues at most one memory access per cycle, guarantees port 1 forward progress with a starvation counter, and returns registered read data to each port.

## Interface
Parameters:
- MAX_WAIT, 4: consecutive cycles port 1 may be deferred by port 0 before one port 1 beat is forced (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 access request (single beat)
- p0_we  in  1  port 0 write enable
- p0_addr  in  32  port 0 byte address, passed through unmodified
- p0_wdata  in  32  port 0 write data
- p0_be  in  4  port 0 byte enables
- p0_gnt  out  1  port 0 access executes this cycle (combinational)
- p0_rdata  out  32  port 0 registered read data
- p0_rvalid  out  1  p0_rdata valid (one-cycle pulse)
- p1_req  in  1  port 1 burst request
- p1_we  in  1  port 1 burst direction (1 = write), sampled at acceptance
- p1_addr  in  32  burst base address; bits [1:0] forced to 0
- p1_len  in  4  beats minus one (0 → 1 beat, 15 → 16 beats), sampled at acceptance
- p1_wdata  in  32  write data for the beat currently indicated by p1_beat
- p1_gnt  out  1  burst accepted this cycle (beat 0 also executes)
- p1_beat  out  1  a port 1 beat executes this cycle (combinational)
- p1_beat_idx  out  4  index of the executing or next beat
- p1_rdata  out  32  port 1 registered read data
- p1_rvalid  out  1  p1_rdata valid (one-cycle pulse)
- p1_done  out  1  one-cycle pulse, cycle after the last beat executes
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables (4'hF for port 1 beats)
- mem_rdata  in  32  combinational memory read data

## Operation
- States: IDLE (no burst active) and BURST (burst registers base, len, we, idx valid).
- p1 pending = (IDLE and p1_req) or BURST.
- Serve p1 when p1 pending and (!p0_req or wait_cnt == MAX_WAIT); otherwise serve p0 if p0_req; otherwise no access (mem_we=0).
- wait_cnt: increments when p1 pending and p0 is served; clears when a p1 beat is served or p1 is not pending. Saturates at MAX_WAIT.
- IDLE + p1 served: p1_gnt=1, beat 0 at p1_addr&~3, latch base/len/we; if p1_len==0 remain IDLE and pulse p1_done next cycle, else idx←1 and go to BURST.
- BURST + p1 served: address = base + 4*idx, modulo 2^32 (wraps). If idx==len → IDLE and pulse p1_done next cycle; else idx←idx+1.
- p1_req is ignored while in BURST; a new burst may be accepted in the cycle after the return to IDLE.
- Port 0 mux: mem_we=p0_we, mem_addr=p0_addr, mem_wdata=p0_wdata, mem_be=p0_be. Port 1: mem_we=latched we (p1_we in the accept cycle), mem_wdata=p1_wdata.
- Reads: on a served read, mem_rdata is captured into the serving port's rdata register, and rvalid pulses the next cycle. Writes produce no rvalid.
- p0 stalls the pipeline by observing p0_req & !p0_gnt.

## Timing
- Grant, beat, and memory outputs are combinational in the access cycle. Read data latency is 1 cycle.
- Reset (priority over everything): state IDLE; wait_cnt, idx, p0_rvalid, p1_rvalid, p1_done = 0; rdata registers = 0. mem_we forced 0 during the reset cycle. A burst in progress is abandoned with no p1_done; the requester re-issues.
- Back-to-back p0 requests: one per cycle, with no bubbles unless a p1 beat is forced.
- Under continuous p0_req during a burst, p1 receives exactly 1 beat every MAX_WAIT+1 cycles.

## Test plan
- Reset, then p0 read at 0x10 with mem holding 0xDEADBEEF: p0_gnt same cycle; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF. All outputs 0 during reset.
- p1 write burst base 0x0000_0103, len=3, p0 idle: 4 consecutive beats at 0x100, 0x104, 0x108, 0x10C with mem_be=F; p1_done pulses one cycle after beat 3; no rvalid.
- p0_req held high, p1 read burst len=1, MAX_WAIT=4: p0 wins cycles 0–3; p1 is accepted on cycle 4 (beat 0); p0 wins cycles 5–8; beat 1 on cycle 9; p1_done on cycle 10.
- p1 burst base 0xFFFF_FFF8, len=3: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset asserted after beat 1 of a 4-beat write: no further mem_we, no p1_done; a new burst is accepted normally afterwards.
- Simultaneous p0_req and p1_req in IDLE with wait_cnt=0: p0_gnt=1, p1_gnt=0, wait_cnt→1.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter
// Two-port arbiter and burst sequencer in front of a single-port word data
// memory. At most one memory access is issued per cycle.
//
// Ports:
//   clk, Reset            clock and synchronous active-high reset
//   p0_*                  port 0 (pipeline MEM stage): single-beat accesses,
//                         normally highest priority; p0_gnt is combinational
//   p1_*                  port 1 (bulk requester): bursts of 1..16 words with
//                         auto-incremented, wrapping addresses; p1_gnt marks
//                         acceptance, p1_beat marks each executing beat,
//                         p1_done pulses the cycle after the last beat
//   mem_*                 memory side; mem_rdata is combinational read data
//
// A starvation counter (wait_cnt) forces one port 1 beat after MAX_WAIT
// consecutive cycles in which port 0 took the memory from a pending port 1.
module dm_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_gnt,
  output logic [31:0] p0_rdata,
  output logic        p0_rvalid,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [3:0]  p1_len,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_beat,
  output logic [3:0]  p1_beat_idx,
  output logic [31:0] p1_rdata,
  output logic        p1_rvalid,
  output logic        p1_done,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] base_q, base_d;
  logic [3:0]  len_q, len_d;
  logic        we_q, we_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic        p0_rvalid_q, p0_rvalid_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p1_rvalid_q, p1_rvalid_d;
  logic        p1_done_q, p1_done_d;

  logic        p1_pending;
  logic        serve_p0;
  logic        serve_p1;
  logic [31:0] beat_addr;
  logic        beat_we;

  // Arbitration. Port 1 normally yields to port 0 but wins once the
  // starvation counter has reached MAX_WAIT. Nothing is served while Reset
  // is high, so the memory sees no write in the reset cycle.
  always_comb begin
    p1_pending = (state_q == IDLE && p1_req) || (state_q == BURST);
    serve_p1   = !Reset && p1_pending && (!p0_req || wait_cnt_q == MAX_WAIT_C);
    serve_p0   = !Reset && p0_req && !serve_p1;
    // In IDLE the beat being served is beat 0 of a burst accepted right now,
    // so its address and direction come straight from the request inputs.
    if (state_q == IDLE) begin
      beat_addr = p1_addr & ~32'd3;
      beat_we   = p1_we;
    end else begin
      beat_addr = base_q + {26'd0, idx_q, 2'b00};
      beat_we   = we_q;
    end
  end

  // State register: every flop of the block, with synchronous reset. An
  // in-flight burst is simply dropped; no p1_done is produced for it.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      base_q      <= 32'd0;
      len_q       <= 4'd0;
      we_q        <= 1'b0;
      idx_q       <= 4'd0;
      p0_rdata_q  <= 32'd0;
      p0_rvalid_q <= 1'b0;
      p1_rdata_q  <= 32'd0;
      p1_rvalid_q <= 1'b0;
      p1_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      base_q      <= base_d;
      len_q       <= len_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      p0_rdata_q  <= p0_rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rdata_q  <= p1_rdata_d;
      p1_rvalid_q <= p1_rvalid_d;
      p1_done_q   <= p1_done_d;
    end
  end

  // Next-state logic: burst sequencing, starvation counter and read capture.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    base_d      = base_q;
    len_d       = len_q;
    we_d        = we_q;
    idx_d       = idx_q;
    p0_rdata_d  = p0_rdata_q;
    p0_rvalid_d = 1'b0;
    p1_rdata_d  = p1_rdata_q;
    p1_rvalid_d = 1'b0;
    p1_done_d   = 1'b0;

    // Read data registers hold their last value between reads.
    if (serve_p0 && !p0_we) begin
      p0_rdata_d  = mem_rdata;
      p0_rvalid_d = 1'b1;
    end
    if (serve_p1 && !beat_we) begin
      p1_rdata_d  = mem_rdata;
      p1_rvalid_d = 1'b1;
    end

    // The counter only runs while port 1 is actually being held off by port 0.
    if (!p1_pending || serve_p1) begin
      wait_cnt_d = 4'd0;
    end else if (serve_p0 && wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    if (serve_p1) begin
      if (state_q == IDLE) begin
        base_d = p1_addr & ~32'd3;
        len_d  = p1_len;
        we_d   = p1_we;
        if (p1_len == 4'd0) begin
          p1_done_d = 1'b1;
        end else begin
          idx_d   = 4'd1;
          state_d = BURST;
        end
      end else if (idx_q == len_q) begin
        idx_d     = 4'd0;
        state_d   = IDLE;
        p1_done_d = 1'b1;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  // Output logic: grants and the memory-side mux. Memory outputs are driven
  // to zero when no access is issued.
  always_comb begin
    p0_gnt      = serve_p0;
    p1_beat     = serve_p1;
    p1_gnt      = serve_p1 && (state_q == IDLE);
    p1_beat_idx = (!Reset && state_q == BURST) ? idx_q : 4'd0;
    p0_rdata    = p0_rdata_q;
    p0_rvalid   = p0_rvalid_q;
    p1_rdata    = p1_rdata_q;
    p1_rvalid   = p1_rvalid_q;
    p1_done     = p1_done_q;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_be      = 4'd0;
    if (serve_p1) begin
      mem_we    = beat_we;
      mem_addr  = beat_addr;
      mem_wdata = p1_wdata;
      mem_be    = 4'hF;
    end else if (serve_p0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_be    = p0_be;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
// Self-checking bench for dm_arbiter. A behavioural model expands each
// accepted burst into a queue of word addresses and tracks port 1's
// deferral count as a plain integer; every cycle the DUT's grants, memory
// outputs and registered read/done outputs are compared against it.
module tb_dm_arbiter;

  localparam int MW = 4;

  logic        clk;
  logic        Reset;
  logic        p0_req, p0_we;
  logic [31:0] p0_addr, p0_wdata;
  logic [3:0]  p0_be;
  logic        p0_gnt;
  logic [31:0] p0_rdata;
  logic        p0_rvalid;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr;
  logic [3:0]  p1_len;
  logic [31:0] p1_wdata;
  logic        p1_gnt, p1_beat;
  logic [3:0]  p1_beat_idx;
  logic [31:0] p1_rdata;
  logic        p1_rvalid, p1_done;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic [31:0] salt;

  int vec_count = 0;
  int err_count = 0;

  // Model state
  logic [31:0] beat_queue[$];
  bit          m_busy;
  bit          m_we;
  int          m_idx;
  int          m_wait;
  logic        e_p0_rvalid, e_p1_rvalid, e_done;
  logic [31:0] e_p0_rdata, e_p1_rdata;

  dm_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .Reset(Reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_be(p0_be), .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_len(p1_len),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_beat(p1_beat),
    .p1_beat_idx(p1_beat_idx), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .p1_done(p1_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Memory stand-in: content is a function of address and a per-cycle salt,
  // so a read captured from the wrong address or the wrong cycle shows up.
  function automatic logic [31:0] memval(input logic [31:0] a, input logic [31:0] s);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ s;
  endfunction

  assign mem_rdata = memval(mem_addr, salt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs from the previous edge, drive
  // inputs, check combinational outputs against the model, advance the model.
  task automatic applyStimulus(
    input logic rst, input logic q0, input logic w0, input logic [31:0] a0,
    input logic [31:0] d0, input logic [3:0] b0, input logic q1, input logic w1,
    input logic [31:0] a1, input logic [3:0] l1, input logic [31:0] d1);
    bit          pend, s0, s1;
    int          eidx;
    logic        ewe;
    logic [31:0] ea, ewd;
    logic [3:0]  ebe;
    @(negedge clk);
    checkOutput("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, e_p0_rvalid});
    checkOutput("p0_rdata", p0_rdata, e_p0_rdata);
    checkOutput("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, e_p1_rvalid});
    checkOutput("p1_rdata", p1_rdata, e_p1_rdata);
    checkOutput("p1_done", {31'd0, p1_done}, {31'd0, e_done});

    Reset = rst; p0_req = q0; p0_we = w0; p0_addr = a0; p0_wdata = d0; p0_be = b0;
    p1_req = q1; p1_we = w1; p1_addr = a1; p1_len = l1; p1_wdata = d1;
    salt = $urandom;
    #1;

    if (rst) begin
      s0 = 0; s1 = 0; pend = 0; eidx = 0;
    end else begin
      pend = m_busy || q1;
      s1   = pend && (!q0 || m_wait >= MW);
      s0   = q0 && !s1;
      eidx = m_busy ? m_idx : 0;
      if (s1 && !m_busy) begin
        beat_queue.delete();
        for (int k = 0; k <= int'(l1); k++)
          beat_queue.push_back((a1 & ~32'd3) + 32'(4 * k));
        m_we  = w1;
        m_idx = 0;
      end
    end
    ewe = 0; ea = 0; ewd = 0; ebe = 0;
    if (s1) begin
      ewe = m_we; ea = beat_queue[0]; ewd = d1; ebe = 4'hF;
    end else if (s0) begin
      ewe = w0; ea = a0; ewd = d0; ebe = b0;
    end

    checkOutput("p0_gnt", {31'd0, p0_gnt}, {31'd0, s0});
    checkOutput("p1_gnt", {31'd0, p1_gnt}, {31'd0, s1 && !m_busy});
    checkOutput("p1_beat", {31'd0, p1_beat}, {31'd0, s1});
    checkOutput("p1_beat_idx", {28'd0, p1_beat_idx}, 32'(eidx));
    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, ewe});
    if (s0 || s1) begin
      checkOutput("mem_addr", mem_addr, ea);
      checkOutput("mem_wdata", mem_wdata, ewd);
      checkOutput("mem_be", {28'd0, mem_be}, {28'd0, ebe});
    end

    if (rst) begin
      beat_queue.delete();
      m_busy = 0; m_idx = 0; m_wait = 0;
      e_p0_rvalid = 0; e_p1_rvalid = 0; e_done = 0;
      e_p0_rdata = 0; e_p1_rdata = 0;
    end else begin
      e_p0_rvalid = s0 && !w0;
      if (e_p0_rvalid) e_p0_rdata = memval(a0, salt);
      e_p1_rvalid = s1 && !m_we;
      if (e_p1_rvalid) e_p1_rdata = memval(ea, salt);
      e_done = 0;
      if (s1) begin
        void'(beat_queue.pop_front());
        m_idx++;
        m_busy = (beat_queue.size() != 0);
        e_done = !m_busy;
      end
      if (s1 || !pend) m_wait = 0;
      else if (m_wait < MW) m_wait++;
    end
  endtask

  task automatic idle(input int n, input logic rst);
    for (int i = 0; i < n; i++)
      applyStimulus(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1; p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_len = 0; p1_wdata = 0; salt = 0;
    beat_queue.delete();
    m_busy = 0; m_we = 0; m_idx = 0; m_wait = 0;
    e_p0_rvalid = 0; e_p1_rvalid = 0; e_done = 0; e_p0_rdata = 0; e_p1_rdata = 0;
    @(posedge clk);

    // Reset, then a port 0 read of 0x10
    idle(2, 1);
    applyStimulus(0, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0);
    idle(1, 0);

    // Four-beat write burst from an unaligned base, port 0 idle
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0103, 4'd3, 32'hA0);
    for (int i = 1; i < 4; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA0 + 32'(i));
    idle(2, 0);

    // Port 0 held busy while a two-beat read burst waits
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 1, 0, 32'h200 + 32'(4 * i), 0, 4'h3, i < 5, 0, 32'h300, 4'd1, 0);
    idle(2, 0);

    // Address wrap at the top of the address space
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFF8, 4'd3, 0);
    idle(5, 0);

    // Reset in the middle of a write burst, then a fresh burst
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h400, 4'd3, 32'h11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22);
    idle(1, 1);
    idle(2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h500, 4'd2, 32'h33);
    idle(4, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a1;
      a1 = ($urandom_range(9) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(63))) : $urandom;
      applyStimulus($urandom_range(99) == 0,
                    $urandom_range(99) < 60, 1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(99) < 40, 1'($urandom), a1, 4'($urandom), $urandom);
    end
    idle(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
